picosoc_slotcfg: RTL

Parametrised PicoSoC iomem peripheral for Apple II slot-card configuration. Firmware writes per-slot card IDs into shadow registers. A commit then walks all slots in order, issues a write pulse to the slotmaker for each changed slot, and optionally follows with a reconfigure pulse. It sits between the PicoSoC iomem bus and the slotmaker configuration port. It also provides live readback of every slot and a busy/pending status word.

---
 rtl/picosoc_slotcfg_pkg.sv | 29 ++
 rtl/picosoc_slotcfg_if.sv | 12 +
 rtl/picosoc_slotcfg_seq.sv | 90 +++++++++
 rtl/picosoc_slotcfg.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/picosoc_slotcfg_pkg.sv
// Shared constants and types for the PicoSoC slot-card configuration peripheral.
// Register offsets, STATUS bit positions and the commit FSM state encoding.
package picosoc_slotcfg_pkg;

   localparam logic [9:0] OFS_SHADOW = 10'h000;
   localparam logic [9:0] OFS_COMMIT = 10'h100;
   localparam logic [9:0] OFS_STATUS = 10'h104;
   localparam logic [9:0] OFS_IRQCLR = 10'h108;
   localparam logic [9:0] OFS_LIVE   = 10'h200;

   localparam int STAT_BUSY = 0;
   localparam int STAT_IRQ  = 1;
   localparam int STAT_PEND = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WALK  = 2'd1,
      RECON = 2'd2,
      DONE  = 2'd3
   } slotcfg_state_t;

   typedef enum logic [1:0] {
      RD_ZERO   = 2'd0,
      RD_SHADOW = 2'd1,
      RD_STATUS = 2'd2,
      RD_LIVE   = 2'd3
   } rd_sel_t;

endpackage

// File: rtl/picosoc_slotcfg_if.sv
// PicoSoC iomem bus bundle between the CPU (master) and the slot-config peripheral (slave).
interface picosoc_slotcfg_if;
   logic        valid;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport master (output valid, wstrb, addr, wdata, input rdata, ready);
   modport slave  (input valid, wstrb, addr, wdata, output rdata, ready);
endinterface

// File: rtl/picosoc_slotcfg_seq.sv
// Commit sequencer: walks every slot, strobes cfg_wr for pending ones, then optional reconfigure.
//   state | meaning
//   IDLE  | waiting for COMMIT; cfg_slot follows LIVE read index
//   WALK  | cfg_slot = idx, cfg_wr high when PEND[idx] was set
//   RECON | one-cycle cfg_reconfig strobe, cfg_slot held at last slot
//   DONE  | one cycle, raises the irq flag in the top level
module picosoc_slotcfg_seq
   import picosoc_slotcfg_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int CARD_W    = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                recon_req,
   input  logic                                live_ld,
   input  logic [$clog2(NUM_SLOTS)-1:0]        live_slot,
   input  logic [NUM_SLOTS-1:0]                pend,
   input  logic [NUM_SLOTS-1:0][CARD_W-1:0]    shadow,
   output logic                                busy,
   output logic                                done,
   output logic [NUM_SLOTS-1:0]                pend_clr,
   output logic [$clog2(NUM_SLOTS)-1:0]        cfg_slot,
   output logic [CARD_W-1:0]                   cfg_card_i,
   output logic                                cfg_wr,
   output logic                                cfg_reconfig
);
   localparam int SW = $clog2(NUM_SLOTS);
   localparam logic [SW-1:0] LAST = SW'(NUM_SLOTS - 1);

   slotcfg_state_t state;
   logic           recon_flag;
   logic [SW-1:0]  nxt;

   assign nxt  = cfg_slot + SW'(1);
   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // cfg_slot doubles as the walk index, so a strobe always names the slot being visited
   always_comb begin
      pend_clr = '0;
      if (state == WALK && cfg_wr) pend_clr[cfg_slot] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         recon_flag   <= 1'b0;
         cfg_slot     <= '0;
         cfg_card_i   <= '0;
         cfg_wr       <= 1'b0;
         cfg_reconfig <= 1'b0;
      end else begin
         cfg_wr       <= 1'b0;
         cfg_reconfig <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  recon_flag <= recon_req;
                  cfg_slot   <= '0;
                  state      <= WALK;
                  if (pend[0]) begin
                     cfg_wr     <= 1'b1;
                     cfg_card_i <= shadow[0];
                  end
               end else if (live_ld) begin
                  cfg_slot <= live_slot;
               end
            end
            WALK: begin
               if (cfg_slot == LAST) begin
                  cfg_reconfig <= recon_flag;
                  state        <= recon_flag ? RECON : DONE;
               end else begin
                  cfg_slot <= nxt;
                  if (pend[nxt]) begin
                     cfg_wr     <= 1'b1;
                     cfg_card_i <= shadow[nxt];
                  end
               end
            end
            RECON:   state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/picosoc_slotcfg.sv
// PicoSoC iomem peripheral holding per-slot shadow card IDs and committing them to the slotmaker.
// Optional commit-done interrupt flag and commit_irq port built only when SLOTCFG_IRQ_EN is defined.
module picosoc_slotcfg
   import picosoc_slotcfg_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int CARD_W    = 8,
   parameter int READY_LAT = 3
) (
   input  logic                           clk,
   input  logic                           reset,
   picosoc_slotcfg_if.slave               bus,
   output logic [$clog2(NUM_SLOTS)-1:0]   cfg_slot,
   output logic [CARD_W-1:0]              cfg_card_i,
   output logic                           cfg_wr,
   output logic                           cfg_reconfig,
   input  logic [CARD_W-1:0]              cfg_card_o
`ifdef SLOTCFG_IRQ_EN
   ,
   output logic                           commit_irq
`endif
);
   localparam int SW = $clog2(NUM_SLOTS);
   localparam logic [5:0] NS6    = 6'(NUM_SLOTS);
   localparam logic [3:0] LAT_LD = 4'(READY_LAT - 1);

   logic [NUM_SLOTS-1:0][CARD_W-1:0] shadow;
   logic [NUM_SLOTS-1:0]             pend, pend_set, pend_clr;
   logic                             busy, done;
   logic                             armed;
   logic [3:0]                       lat_cnt;
   logic                             ready_q;
   logic [31:0]                      rdata_q;
   rd_sel_t                          rd_sel, rd_nxt;
   logic [SW-1:0]                    rd_slot;
   logic                             irq_flag;

   logic [9:0]    ofs;
   logic [5:0]    word;
   logic [SW-1:0] slot;
   logic          wr, in_range, stall, acc;
   logic          hit_shadow, hit_live, hit_commit, hit_status, hit_irqclr;
   logic          sh_we, start, live_ld;
   logic [31:0]   status;

   assign ofs        = bus.addr[9:0];
   assign word       = ofs[7:2];
   assign slot       = word[SW-1:0];
   assign wr         = |bus.wstrb;
   assign in_range   = (word < NS6);
   assign hit_shadow = ({ofs[9:8], 8'h00} == OFS_SHADOW);
   assign hit_live   = ({ofs[9:8], 8'h00} == OFS_LIVE);
   assign hit_commit = ({ofs[9:2], 2'b00} == OFS_COMMIT);
   assign hit_status = ({ofs[9:2], 2'b00} == OFS_STATUS);
   assign hit_irqclr = ({ofs[9:2], 2'b00} == OFS_IRQCLR);

   // Accesses that touch the walk's inputs or cfg_slot wait for the commit to finish
   assign stall   = busy && ((wr && (hit_shadow || hit_commit)) || (!wr && hit_live));
   assign acc     = bus.valid && armed && (lat_cnt == 4'd0) && !stall;
   assign sh_we   = acc && wr && hit_shadow && in_range;
   assign start   = acc && wr && hit_commit;
   assign live_ld = acc && !wr && hit_live && in_range;

   always_comb begin
      rd_nxt = RD_ZERO;
      if (!wr) begin
         if (hit_shadow && in_range)    rd_nxt = RD_SHADOW;
         else if (hit_status)           rd_nxt = RD_STATUS;
         else if (hit_live && in_range) rd_nxt = RD_LIVE;
      end
   end

   always_comb begin
      pend_set = '0;
      if (sh_we) pend_set[slot] = 1'b1;
   end

   always_comb begin
      status                        = '0;
      status[STAT_BUSY]             = busy;
      status[STAT_IRQ]              = irq_flag;
      status[STAT_PEND +: NUM_SLOTS] = pend;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed   <= 1'b1;
         lat_cnt <= 4'd0;
         ready_q <= 1'b0;
         rdata_q <= '0;
         rd_sel  <= RD_ZERO;
         rd_slot <= '0;
         shadow  <= '0;
         pend    <= '0;
      end else begin
         ready_q <= (lat_cnt == 4'd1);
         if (acc) begin
            armed   <= 1'b0;
            lat_cnt <= LAT_LD;
            rd_sel  <= rd_nxt;
            rd_slot <= slot;
         end else begin
            if (!bus.valid)      armed   <= 1'b1;
            if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
         end
         if (lat_cnt == 4'd1) begin
            case (rd_sel)
               RD_SHADOW: rdata_q <= 32'(shadow[rd_slot]);
               RD_STATUS: rdata_q <= status;
               RD_LIVE:   rdata_q <= 32'(cfg_card_o);
               default:   rdata_q <= '0;
            endcase
         end
         if (sh_we) shadow[slot] <= bus.wdata[CARD_W-1:0];
         pend <= (pend & ~pend_clr) | pend_set;
      end
   end

`ifdef SLOTCFG_IRQ_EN
   // Set wins over a same-cycle clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                    irq_flag <= 1'b0;
      else if (done)                                irq_flag <= 1'b1;
      else if (acc && wr && (hit_irqclr || hit_commit)) irq_flag <= 1'b0;
   end
   assign commit_irq = irq_flag;
   logic unused_bits;
   assign unused_bits = ^{bus.addr[31:10], bus.addr[1:0], bus.wdata[31:CARD_W]};
`else
   assign irq_flag = 1'b0;
   logic unused_bits;
   assign unused_bits = ^{bus.addr[31:10], bus.addr[1:0], bus.wdata[31:CARD_W], done, hit_irqclr};
`endif

   assign bus.ready = ready_q;
   assign bus.rdata = rdata_q;

   picosoc_slotcfg_seq #(
      .NUM_SLOTS (NUM_SLOTS),
      .CARD_W    (CARD_W)
   ) u_seq (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .recon_req    (bus.wdata[0]),
      .live_ld      (live_ld),
      .live_slot    (slot),
      .pend         (pend),
      .shadow       (shadow),
      .busy         (busy),
      .done         (done),
      .pend_clr     (pend_clr),
      .cfg_slot     (cfg_slot),
      .cfg_card_i   (cfg_card_i),
      .cfg_wr       (cfg_wr),
      .cfg_reconfig (cfg_reconfig)
   );

endmodule
